// File: rtl/if_id_skid_stage_pkg.sv
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared constants for the IF/ID elastic stage: the default bubble
//             instruction, the occupancy state encoding and the PC increments.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Instruction word presented for bubbles (all-zero is a MIPS-style NOP)
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Occupancy encoding, which doubles as the stage state
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // Sequential PC increments precomputed at capture
    localparam int unsigned PC_INC4 = 4;
    localparam int unsigned PC_INC8 = 8;

endpackage

`default_nettype wire

// File: rtl/if_id_skid_stage_if.sv
// ============================================================================
//  Module   : if_id_skid_stage_if
//  Purpose  : Fetch/decode handshake bundle for the IF/ID elastic stage.
//             master = fetch/decode environment, slave = the stage itself.
//             Optional IFID_ADEL_CHK_EN adds the out_adel signal.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_id_skid_stage_if #(
    parameter int IW = 32,
    parameter int AW = 32
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_pc;
    logic [IW-1:0] in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc4;
    logic [AW-1:0] out_pc8;
    logic [1:0]    occupancy;
`ifdef IFID_ADEL_CHK_EN
    logic          out_adel;
`endif

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
`ifdef IFID_ADEL_CHK_EN
        input  out_adel,
`endif
        input  in_ready, out_valid, out_pc, out_instr, out_pc4, out_pc8, occupancy
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
`ifdef IFID_ADEL_CHK_EN
        output out_adel,
`endif
        output in_ready, out_valid, out_pc, out_instr, out_pc4, out_pc8, occupancy
    );

endinterface

`default_nettype wire

// File: rtl/if_id_skid_stage_entry.sv
// ============================================================================
//  Module   : pipe_entry
//  Purpose  : One storage slot of the IF/ID stage: {valid, pc, instr, pc4,
//             pc8[, adel]} with load and clear. Clear squashes to a bubble
//             but keeps the PC fields; reset zeroes everything.
//             Optional IFID_ADEL_CHK_EN adds the adel field.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_entry #(
    parameter int            IW       = 32,
    parameter int            AW       = 32,
    parameter logic [IW-1:0] NOP_WORD = '0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          load_i,
    input  wire logic          clear_i,
    input  wire logic [AW-1:0] pc_i,
    input  wire logic [IW-1:0] instr_i,
    input  wire logic [AW-1:0] pc4_i,
    input  wire logic [AW-1:0] pc8_i,
`ifdef IFID_ADEL_CHK_EN
    input  wire logic          adel_i,
    output logic               adel_o,
`endif
    output logic               valid_o,
    output logic [AW-1:0]      pc_o,
    output logic [IW-1:0]      instr_o,
    output logic [AW-1:0]      pc4_o,
    output logic [AW-1:0]      pc8_o
);

    logic          valid_q;
    logic [AW-1:0] pc_q;
    logic [IW-1:0] instr_q;
    logic [AW-1:0] pc4_q;
    logic [AW-1:0] pc8_q;
`ifdef IFID_ADEL_CHK_EN
    logic          adel_q;
`endif

    // Slot register: reset > clear (bubble, PC kept) > load
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            pc8_q   <= '0;
`ifdef IFID_ADEL_CHK_EN
            adel_q  <= 1'b0;
`endif
        end else if (clear_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
`ifdef IFID_ADEL_CHK_EN
            adel_q  <= 1'b0;
`endif
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            pc8_q   <= pc8_i;
`ifdef IFID_ADEL_CHK_EN
            adel_q  <= adel_i;
`endif
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign pc8_o   = pc8_q;
`ifdef IFID_ADEL_CHK_EN
    assign adel_o  = adel_q;
`endif

endmodule

`default_nettype wire

// File: rtl/if_id_skid_stage.sv
// ============================================================================
//  Module   : if_id_skid_stage
//  Purpose  : Two-entry elastic IF/ID stage (head + skid) with valid/ready
//             handshake, flush-to-bubble and PC+4/PC+8 derived at capture.
//             in_ready is registered (= !skid valid).
//             Optional IFID_ADEL_CHK_EN flags misaligned fetch PCs (out_adel).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int            IW       = 32,
    parameter int            AW       = 32,
    parameter logic [IW-1:0] NOP_WORD = IW'(NOP_WORD_DEFAULT)
) (
    input  wire logic            clk,
    input  wire logic            reset,
    if_id_skid_stage_if.slave    bus
);

    logic [1:0]    state_q, state_d;
    logic          push, pop;
    logic          head_load, head_from_skid, head_clear;
    logic          skid_load, skid_clear;

    logic          head_valid, skid_valid;
    logic [AW-1:0] skid_pc, skid_pc4, skid_pc8;
    logic [IW-1:0] skid_instr;

    logic [AW-1:0] cap_pc4, cap_pc8;
    logic [IW-1:0] cap_instr;
    logic [AW-1:0] head_pc_in, head_pc4_in, head_pc8_in;
    logic [IW-1:0] head_instr_in;

    assign push = bus.in_valid && !skid_valid;
    assign pop  = head_valid && bus.out_ready;

    // Capture-side derived fields; the increments wrap silently
    assign cap_pc4 = bus.in_pc + AW'(PC_INC4);
    assign cap_pc8 = bus.in_pc + AW'(PC_INC8);

`ifdef IFID_ADEL_CHK_EN
    logic cap_adel, skid_adel, head_adel_in;
    assign cap_adel     = |bus.in_pc[1:0];
    // A misaligned fetch carries a bubble instruction but stays valid
    assign cap_instr    = cap_adel ? NOP_WORD : bus.in_instr;
    assign head_adel_in = head_from_skid ? skid_adel : cap_adel;
`else
    assign cap_instr    = bus.in_instr;
`endif

    assign head_pc_in    = head_from_skid ? skid_pc    : bus.in_pc;
    assign head_instr_in = head_from_skid ? skid_instr : cap_instr;
    assign head_pc4_in   = head_from_skid ? skid_pc4   : cap_pc4;
    assign head_pc8_in   = head_from_skid ? skid_pc8   : cap_pc8;

    // Occupancy state transitions and entry controls; flush wins over push/pop
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        head_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (bus.flush) begin
            state_d    = OCC_EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        state_d   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push) begin
                        skid_load = 1'b1;
                        state_d   = OCC_TWO;
                    end else if (pop) begin
                        head_clear = 1'b1;
                        state_d    = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = OCC_ONE;
                    end
                end
                default: begin
                    state_d    = OCC_EMPTY;
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= OCC_EMPTY;
        else       state_q <= state_d;
    end

    pipe_entry #(.IW(IW), .AW(AW), .NOP_WORD(NOP_WORD)) u_head (
        .clk     (clk),
        .reset   (reset),
        .load_i  (head_load),
        .clear_i (head_clear),
        .pc_i    (head_pc_in),
        .instr_i (head_instr_in),
        .pc4_i   (head_pc4_in),
        .pc8_i   (head_pc8_in),
`ifdef IFID_ADEL_CHK_EN
        .adel_i  (head_adel_in),
        .adel_o  (bus.out_adel),
`endif
        .valid_o (head_valid),
        .pc_o    (bus.out_pc),
        .instr_o (bus.out_instr),
        .pc4_o   (bus.out_pc4),
        .pc8_o   (bus.out_pc8)
    );

    pipe_entry #(.IW(IW), .AW(AW), .NOP_WORD(NOP_WORD)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (bus.in_pc),
        .instr_i (cap_instr),
        .pc4_i   (cap_pc4),
        .pc8_i   (cap_pc8),
`ifdef IFID_ADEL_CHK_EN
        .adel_i  (cap_adel),
        .adel_o  (skid_adel),
`endif
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr),
        .pc4_o   (skid_pc4),
        .pc8_o   (skid_pc8)
    );

    assign bus.out_valid = head_valid;
    assign bus.in_ready  = !skid_valid;
    assign bus.occupancy = state_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_stage.sv
// ============================================================================
//  Module   : tb_if_id_skid_stage
//  Purpose  : Directed self-checking bench for if_id_skid_stage.
//             Honours IFID_ADEL_CHK_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_skid_stage;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    if_id_skid_stage_if #(.IW(32), .AW(32)) bus ();

    if_id_skid_stage #(.IW(32), .AW(32), .NOP_WORD(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_instr"}, 64'(bus.out_instr), 64'd0);
        check({tag, "_pc"},    64'(bus.out_pc),    64'd0);
        check({tag, "_pc4"},   64'(bus.out_pc4),   64'd0);
        check({tag, "_pc8"},   64'(bus.out_pc8),   64'd0);
        check({tag, "_occ"},   64'(bus.occupancy), 64'd0);
        check({tag, "_rdy"},   64'(bus.in_ready),  64'd1);
`ifdef IFID_ADEL_CHK_EN
        check({tag, "_adel"},  64'(bus.out_adel),  64'd0);
`endif
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("reset");

        // Single beat, 1-cycle latency
        drive(1'b1, 32'h0000_3000, 32'h2401_0005, 1'b1, 1'b0);
        tick();
        check("p1_valid", 64'(bus.out_valid), 64'd1);
        check("p1_pc",    64'(bus.out_pc),    64'h3000);
        check("p1_pc4",   64'(bus.out_pc4),   64'h3004);
        check("p1_pc8",   64'(bus.out_pc8),   64'h3008);
        check("p1_instr", 64'(bus.out_instr), 64'h2401_0005);
        check("p1_occ",   64'(bus.occupancy), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("p1_pop_occ",   64'(bus.occupancy), 64'd0);
        check("p1_pop_instr", 64'(bus.out_instr), 64'd0);

        // Back-pressure fills the skid, third beat waits at fetch
        drive(1'b1, 32'h0000_3000, 32'h1111_0000, 1'b0, 1'b0);
        tick();
        check("bp_occ1", 64'(bus.occupancy), 64'd1);
        check("bp_rdy1", 64'(bus.in_ready),  64'd1);
        drive(1'b1, 32'h0000_3004, 32'h1111_0004, 1'b0, 1'b0);
        tick();
        check("bp_occ2", 64'(bus.occupancy), 64'd2);
        check("bp_rdy2", 64'(bus.in_ready),  64'd0);
        check("bp_pc2",  64'(bus.out_pc),    64'h3000);
        drive(1'b1, 32'h0000_3008, 32'h1111_0008, 1'b0, 1'b0);
        tick();
        check("bp_hold_occ", 64'(bus.occupancy), 64'd2);
        check("bp_hold_pc",  64'(bus.out_pc),    64'h3000);
        drive(1'b1, 32'h0000_3008, 32'h1111_0008, 1'b1, 1'b0);
        tick();
        check("dr1_pc",    64'(bus.out_pc),    64'h3004);
        check("dr1_instr", 64'(bus.out_instr), 64'h1111_0004);
        check("dr1_pc4",   64'(bus.out_pc4),   64'h3008);
        check("dr1_occ",   64'(bus.occupancy), 64'd1);
        check("dr1_rdy",   64'(bus.in_ready),  64'd1);
        tick();
        check("dr2_pc",    64'(bus.out_pc),    64'h3008);
        check("dr2_instr", 64'(bus.out_instr), 64'h1111_0008);
        check("dr2_occ",   64'(bus.occupancy), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("dr3_occ",   64'(bus.occupancy), 64'd0);
        check("dr3_valid", 64'(bus.out_valid), 64'd0);

        // Flush while full, with an input beat in the same cycle
        drive(1'b1, 32'h0000_4000, 32'h2222_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_4004, 32'h2222_0004, 1'b0, 1'b0);
        tick();
        check("fl_pre_occ", 64'(bus.occupancy), 64'd2);
        drive(1'b1, 32'h0000_5000, 32'h3333_0000, 1'b1, 1'b1);
        tick();
        check("fl_occ",   64'(bus.occupancy), 64'd0);
        check("fl_valid", 64'(bus.out_valid), 64'd0);
        check("fl_instr", 64'(bus.out_instr), 64'd0);
        check("fl_rdy",   64'(bus.in_ready),  64'd1);
        check("fl_pc",    64'(bus.out_pc),    64'h4000);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("fl_after_valid", 64'(bus.out_valid), 64'd0);
        check("fl_after_occ",   64'(bus.occupancy), 64'd0);

        // PC wrap-around
        drive(1'b1, 32'hFFFF_FFFC, 32'h4444_0000, 1'b1, 1'b0);
        tick();
        check("wr_pc",  64'(bus.out_pc),  64'hFFFF_FFFC);
        check("wr_pc4", 64'(bus.out_pc4), 64'h0);
        check("wr_pc8", 64'(bus.out_pc8), 64'h4);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // Reset beats flush while full
        drive(1'b1, 32'h0000_6000, 32'h5555_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_6004, 32'h5555_0004, 1'b0, 1'b0);
        tick();
        check("rs_pre_occ", 64'(bus.occupancy), 64'd2);
        reset = 1'b1;
        drive(1'b1, 32'h0000_7000, 32'h6666_0000, 1'b0, 1'b1);
        tick();
        check_reset_state("rs");
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // Misaligned PC
        drive(1'b1, 32'h0000_3002, 32'h1234_5678, 1'b1, 1'b0);
        tick();
        check("ad_valid", 64'(bus.out_valid), 64'd1);
`ifdef IFID_ADEL_CHK_EN
        check("ad_adel",  64'(bus.out_adel),  64'd1);
        check("ad_instr", 64'(bus.out_instr), 64'd0);
`else
        check("ad_instr", 64'(bus.out_instr), 64'h1234_5678);
`endif
        drive(1'b1, 32'h0000_3004, 32'h0000_0011, 1'b1, 1'b0);
        tick();
`ifdef IFID_ADEL_CHK_EN
        check("ad2_adel", 64'(bus.out_adel),  64'd0);
`endif
        check("ad2_instr", 64'(bus.out_instr), 64'h11);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
